// File: rtl/instr_fetch_unit.sv
// Fetch stage for the MIPS core: holds the PC, fetches one word at a time over a req/ready
// handshake, issues it to the control unit and resolves the next PC from branch/jump flags.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_f,
   input  logic        jump_f,
   input  logic        alu_zero,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      EXEC
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] next_pc;
   logic [31:0] branch_off;
   logic        retire;

   assign pc_plus4   = pc + 32'd4;
   assign imem_addr  = pc;
   assign op         = instr[31:26];
   assign funct      = instr[5:0];
   assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign retire     = (state == EXEC) && !stall;

   // Jump takes priority over a taken branch; both are relative to pc_plus4.
   always_comb begin
      next_pc = pc_plus4;
      if (jump_f) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (branch_f && alu_zero) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (!stall) begin
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Instruction capture only happens in REQ, so a ready arriving while idle is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         instr       <= 32'h0000_0000;
         retired_cnt <= 32'h0000_0000;
      end else begin
         if ((state == REQ) && imem_ready) begin
            instr <= imem_rdata;
         end
         if (retire) begin
            pc          <= next_pc;
            retired_cnt <= retired_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed instruction sequence, a cycle-level reference model
// compared every cycle, and literal expectations on the PC/counter at key points.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_f;
   logic        jump_f;
   logic        alu_zero;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] retired_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit          m_started = 0;
   bit          m_fetching = 0;
   bit          m_issued = 0;
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_instr = 32'h0;
   logic [31:0] m_retires = 32'h0;
   logic [31:0] cnt_base = 32'h0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ready(imem_ready),
      .imem_rdata(imem_rdata),
      .stall(stall),
      .branch_f(branch_f),
      .jump_f(jump_f),
      .alu_zero(alu_zero),
      .instr_valid(instr_valid),
      .instr(instr),
      .op(op),
      .funct(funct),
      .pc(pc),
      .pc_plus4(pc_plus4),
      .retired_cnt(retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Target address from MIPS rules: word index for jumps, signed word offset for branches.
   function automatic logic [31:0] targetOf(input logic [31:0] cur_pc, input logic [31:0] word,
                                            input logic br, input logic j, input logic z);
      logic [31:0]        seq;
      logic signed [15:0] imm;
      int                 off;
      seq = cur_pc + 32'd4;
      imm = word[15:0];
      off = imm;
      if (j) return (seq & 32'hF000_0000) | ({6'b0, word[25:0]} * 32'd4);
      if (br && z) return seq + 32'(off * 4);
      return seq;
   endfunction

   // Model of fetch/issue sequencing: one idle cycle after reset, then alternate fetch/issue.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_started  = 0;
         m_fetching = 0;
         m_issued   = 0;
         m_pc       = 32'h0;
         m_instr    = 32'h0;
         m_retires  = 32'h0;
      end else if (!m_started) begin
         m_started  = 1;
         m_fetching = 1;
      end else if (m_fetching) begin
         if (imem_ready) begin
            m_instr    = imem_rdata;
            m_fetching = 0;
            m_issued   = 1;
         end
      end else if (m_issued && !stall) begin
         m_pc       = targetOf(m_pc, m_instr, branch_f, jump_f, alu_zero);
         m_retires  = m_retires + 32'd1;
         m_issued   = 0;
         m_fetching = 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("imem_req", {31'b0, imem_req}, {31'b0, m_fetching});
         checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_issued});
         checkOutput("pc", pc, m_pc);
         checkOutput("imem_addr", imem_addr, m_pc);
         checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
         checkOutput("instr", instr, m_instr);
         checkOutput("op", {26'b0, op}, {26'b0, m_instr[31:26]});
         checkOutput("funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
         checkOutput("retired_cnt", retired_cnt, m_retires + cnt_base);
      end
   end

   // Drive one cycle of inputs, then return just after the next rising edge.
   task automatic applyStimulus(input logic rdy, input logic [31:0] rdata, input logic stl,
                                input logic br, input logic j, input logic z);
      imem_ready = rdy;
      imem_rdata = rdata;
      stall      = stl;
      branch_f   = br;
      jump_f     = j;
      alu_zero   = z;
      @(posedge clk);
      #1;
   endtask

   // Fetch one word with immediate ready, then retire it with the given control flags.
   task automatic fetchExec(input logic [31:0] word, input logic br, input logic j, input logic z);
      int guard;
      guard = 0;
      while (!imem_req && guard < 10) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      checkOutput("fetch_request_seen", {31'b0, imem_req}, 32'd1);
      applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, br, j, z);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      stall      = 1'b0;
      branch_f   = 1'b0;
      jump_f     = 1'b0;
      alu_zero   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
      checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_instr", instr, 32'h0);
      checkOutput("rst_cnt", retired_cnt, 32'h0);
      rst_n = 1'b1;

      // Ready during the idle gap must not be captured
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("gap_instr", instr, 32'h0);
      checkOutput("gap_req", {31'b0, imem_req}, 32'd1);

      // Sequential nops
      for (int k = 1; k <= 4; k++) begin
         fetchExec(32'h0000_0000, 1'b0, 1'b0, 1'b0);
         checkOutput("seq_addr", imem_addr, 32'(4 * k));
         checkOutput("seq_cnt", retired_cnt, 32'(k));
      end

      // Branches from pc=0x10
      fetchExec(32'h1000_0003, 1'b1, 1'b0, 1'b1);
      checkOutput("beq_fwd", imem_addr, 32'h0000_0020);
      fetchExec(32'h0800_0004, 1'b0, 1'b1, 1'b0);
      checkOutput("j_back", imem_addr, 32'h0000_0010);
      fetchExec(32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
      checkOutput("beq_neg", imem_addr, 32'h0000_0010);
      fetchExec(32'h1000_0003, 1'b1, 1'b0, 1'b0);
      checkOutput("beq_not_taken", imem_addr, 32'h0000_0014);

      // Jumps; second one also has branch asserted
      fetchExec(32'h0810_0002, 1'b0, 1'b1, 1'b0);
      checkOutput("j_far", imem_addr, 32'h0040_0008);
      fetchExec(32'h0810_0000, 1'b1, 1'b1, 1'b1);
      checkOutput("j_over_branch", imem_addr, 32'h0040_0000);
      checkOutput("cnt_10", retired_cnt, 32'd10);

      // Slow memory: ready withheld five cycles
      repeat (5) applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("wait_req", {31'b0, imem_req}, 32'd1);
      checkOutput("wait_addr", imem_addr, 32'h0040_0000);
      checkOutput("wait_valid", {31'b0, instr_valid}, 32'd0);
      applyStimulus(1'b1, 32'h2108_0001, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("late_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("late_op", {26'b0, op}, 32'h8);
      checkOutput("late_funct", {26'b0, funct}, 32'h1);

      // Stall holds everything; flags during stall are ignored
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("stall_instr", instr, 32'h2108_0001);
      checkOutput("stall_pc", pc, 32'h0040_0000);
      checkOutput("stall_cnt", retired_cnt, 32'd10);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("unstall_addr", imem_addr, 32'h0040_0004);
      checkOutput("unstall_cnt", retired_cnt, 32'd11);

      // Asynchronous reset while requesting
      rst_n = 1'b0;
      #1;
      checkOutput("areq_req", {31'b0, imem_req}, 32'd0);
      checkOutput("areq_pc", pc, 32'h0);
      checkOutput("areq_cnt", retired_cnt, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("areq_gap_instr", instr, 32'h0);
      applyStimulus(1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("exec_funct", {26'b0, funct}, 32'h20);

      // Asynchronous reset while executing
      rst_n = 1'b0;
      #1;
      checkOutput("aexec_valid", {31'b0, instr_valid}, 32'd0);
      checkOutput("aexec_instr", instr, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // Counter wrap from all-ones
      force dut.retired_cnt = 32'hFFFF_FFFF;
      cnt_base = 32'hFFFF_FFFF;
      #1;
      release dut.retired_cnt;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("preset_cnt", retired_cnt, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_cnt", retired_cnt, 32'h0);
      checkOutput("wrap_addr", imem_addr, 32'h0000_0004);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
